// File: rtl/mem_responder.sv
// Word-addressed RAM plus memory-mapped LED/switch registers and an optional timer.
// Define MEM_TIMER_EN to build the COUNT/CTRL/CMP/STAT timer block and timer_irq.
module mem_responder #(
  parameter int                WIDTH     = 16,
  parameter int                ADDR_BITS = 10,
  parameter logic [WIDTH-1:0]  IO_BASE   = 16'hFF00,
  parameter int                PRESCALE  = 50
) (
  input  logic             clk50MHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] mem_out,
  input  logic [9:0]       switches,
  output logic [9:0]       leds,
  output logic             timer_irq
);

  localparam logic [WIDTH-1:0] OFF_LED   = WIDTH'(0);
  localparam logic [WIDTH-1:0] OFF_SW    = WIDTH'(1);
`ifdef MEM_TIMER_EN
  localparam logic [WIDTH-1:0] OFF_COUNT = WIDTH'(2);
  localparam logic [WIDTH-1:0] OFF_CTRL  = WIDTH'(3);
  localparam logic [WIDTH-1:0] OFF_CMP   = WIDTH'(4);
  localparam logic [WIDTH-1:0] OFF_STAT  = WIDTH'(5);
  localparam int               PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
`endif

  logic [WIDTH-1:0] ram [0:(2**ADDR_BITS)-1];

  logic             ram_sel, io_sel;
  logic [WIDTH-1:0] io_off;
  logic [WIDTH-1:0] mem_out_d, mem_out_q;
  logic [9:0]       led_d, led_q;
  logic [9:0]       sw_meta_q, sw_sync_q;

  assign ram_sel = (mem_addr >> ADDR_BITS) == '0;
  // Addresses below IO_BASE wrap to large offsets and fall out of range.
  assign io_off  = mem_addr - IO_BASE;
  assign io_sel  = io_off < WIDTH'(6);

`ifdef MEM_TIMER_EN
  logic [PS_W-1:0] ps_d, ps_q;
  logic [15:0]     cnt_d, cnt_q;
  logic [15:0]     cmp_d, cmp_q;
  logic            en_d, en_q;
  logic            flag_d, flag_q;
  logic            tick, clr_wr, match_set;

  always_comb begin
    ps_d      = ps_q;
    cnt_d     = cnt_q;
    cmp_d     = cmp_q;
    en_d      = en_q;
    flag_d    = flag_q;
    clr_wr    = memwrite && io_sel && io_off == OFF_CTRL && writedata[1];
    tick      = en_q && ps_q == PS_W'(PRESCALE - 1);
    match_set = 1'b0;

    if (en_q) ps_d = tick ? '0 : ps_q + 1'b1;
    if (tick) cnt_d = cnt_q + 16'd1;
    // Clear beats a coincident tick, including any match it would have raised.
    if (clr_wr) begin
      ps_d  = '0;
      cnt_d = '0;
    end else begin
      match_set = tick && (cnt_q + 16'd1) == cmp_q;
    end

    if (memwrite && io_sel) begin
      if (io_off == OFF_CTRL) en_d  = writedata[0];
      if (io_off == OFF_CMP)  cmp_d = 16'(writedata);
      if (io_off == OFF_STAT && writedata[0]) flag_d = 1'b0;
    end
    if (match_set) flag_d = 1'b1;
  end

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      ps_q   <= '0;
      cnt_q  <= '0;
      cmp_q  <= '0;
      en_q   <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      en_q   <= en_d;
      flag_q <= flag_d;
    end
  end

  assign timer_irq = flag_q;
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    led_d = led_q;
    if (memwrite && io_sel && io_off == OFF_LED) led_d = writedata[9:0];
  end

  // Read data is taken before this edge's write lands, giving read-first behaviour.
  always_comb begin
    mem_out_d = '0;
    if (ram_sel) begin
      mem_out_d = ram[mem_addr[ADDR_BITS-1:0]];
    end else if (io_sel) begin
      case (io_off)
        OFF_LED:   mem_out_d = WIDTH'(led_q);
        OFF_SW:    mem_out_d = WIDTH'(sw_sync_q);
`ifdef MEM_TIMER_EN
        OFF_COUNT: mem_out_d = WIDTH'(cnt_q);
        OFF_CTRL:  mem_out_d = WIDTH'(en_q);
        OFF_CMP:   mem_out_d = WIDTH'(cmp_q);
        OFF_STAT:  mem_out_d = WIDTH'(flag_q);
`endif
        default:   mem_out_d = '0;
      endcase
    end
  end

  // RAM holds no reset; reset only suppresses a write on the same edge.
  always_ff @(posedge clk50MHz) begin
    if (!reset && memwrite && ram_sel) ram[mem_addr[ADDR_BITS-1:0]] <= writedata;
  end

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      mem_out_q <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      mem_out_q <= mem_out_d;
      led_q     <= led_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign mem_out = mem_out_q;
  assign leds    = led_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; timer checks follow MEM_TIMER_EN.
module tb_mem_responder;
  localparam logic [15:0] IOB = 16'hFF00;

  logic        clk50MHz = 1'b0;
  logic        reset;
  logic [15:0] mem_addr, writedata, mem_out;
  logic        memwrite;
  logic [9:0]  switches, leds;
  logic        timer_irq;

  int n_chk = 0;
  int n_err = 0;

  mem_responder #(.WIDTH(16), .ADDR_BITS(10), .IO_BASE(IOB), .PRESCALE(2)) dut (
    .clk50MHz (clk50MHz),
    .reset    (reset),
    .mem_addr (mem_addr),
    .memwrite (memwrite),
    .writedata(writedata),
    .mem_out  (mem_out),
    .switches (switches),
    .leds     (leds),
    .timer_irq(timer_irq)
  );

  always #5 clk50MHz = ~clk50MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk50MHz);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem_addr = a; writedata = d; memwrite = 1'b1;
    cyc();
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    mem_addr = a; memwrite = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b1; mem_addr = '0; writedata = '0; memwrite = 1'b0; switches = '0;
    cyc(); cyc();
    chk("rst_mem_out", mem_out, 0);
    chk("rst_leds", leds, 0);
    chk("rst_irq", timer_irq, 0);
    reset = 1'b0;

    wr(16'd1, 16'h0005);
    rd(16'd1);                     chk("ram_rd1", mem_out, 16'h0005);

    wr(16'd3, 16'h1234);
    wr(16'd3, 16'hBEEF);           chk("read_first", mem_out, 16'h1234);
    rd(16'd3);                     chk("ram_new", mem_out, 16'hBEEF);

    wr(16'd0, 16'h1111);
    wr(16'h03FF, 16'h7777);
    wr(16'h0400, 16'h2222);
    rd(16'h03FF);                  chk("ram_top", mem_out, 16'h7777);
    rd(16'h0400);                  chk("unmap_0400", mem_out, 0);
    rd(16'd0);                     chk("no_alias", mem_out, 16'h1111);
    wr(16'h8000, 16'h5555);
    rd(16'h8000);                  chk("unmap_8000", mem_out, 0);

    wr(IOB, 16'h03FF);             chk("leds_3ff", leds, 10'h3FF);
    rd(IOB);                       chk("led_rd", mem_out, 16'h03FF);
    wr(IOB, 16'hFC15);             chk("leds_015", leds, 10'h015);
    rd(IOB);                       chk("led_upper0", mem_out, 16'h0015);
    wr(IOB, 16'h03FF);

    switches = 10'h2A3;
    cyc(); cyc(); cyc();
    rd(IOB + 16'd1);               chk("sw_rd", mem_out, 16'h02A3);
    wr(IOB + 16'd1, 16'h0000);
    rd(IOB + 16'd1);               chk("sw_ro", mem_out, 16'h02A3);
    rd(IOB + 16'd6);               chk("unmap_io6", mem_out, 0);

`ifdef MEM_TIMER_EN
    wr(IOB + 16'd4, 16'd3);
    wr(IOB + 16'd3, 16'd1);
    mem_addr = IOB + 16'd2;
    for (int i = 0; i < 5; i++) cyc();
    chk("irq_early", timer_irq, 0);
    cyc();                         chk("irq_match", timer_irq, 1);
    cyc();                         chk("count_3", mem_out, 16'd3);
    wr(IOB + 16'd5, 16'd1);        chk("irq_clr", timer_irq, 0);
    wr(IOB + 16'd3, 16'd2);
    rd(IOB + 16'd2);               chk("count_clr", mem_out, 0);
    rd(IOB + 16'd3);               chk("ctrl_rd", mem_out, 0);
    rd(IOB + 16'd4);               chk("cmp_rd", mem_out, 16'd3);
`else
    wr(IOB + 16'd2, 16'h1234);
    rd(IOB + 16'd2);               chk("no_timer_cnt", mem_out, 0);
    wr(IOB + 16'd3, 16'h0001);
    rd(IOB + 16'd3);               chk("no_timer_ctrl", mem_out, 0);
    chk("no_timer_irq", timer_irq, 0);
`endif

    wr(16'd7, 16'h0707);
    rd(16'd7);
    mem_addr = 16'd7; writedata = 16'hDEAD; memwrite = 1'b1;
    reset = 1'b1;
    cyc();
    chk("rst_wr_out", mem_out, 0);
    chk("rst_wr_leds", leds, 0);
    chk("rst_wr_irq", timer_irq, 0);
    memwrite = 1'b0;
    reset = 1'b0;
    rd(16'd7);                     chk("rst_wr_keep", mem_out, 16'h0707);
    rd(16'd1);                     chk("ram_kept", mem_out, 16'h0005);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
